// File: rtl/tick_scheduler.sv
// tick_scheduler: quarter-second prescaler sequenced into sec_tick / inc_pulse strobes and a blink enable.
// Latency: every output is registered; a button press gives inc_pulse one cycle after the first high sample.
// Optional auto-repeat while held: define TICK_SCHED_AUTO_REPEAT_EN (undefined: one pulse per press).
module tick_scheduler #(
   parameter int QTR_DIV      = 2500,
   parameter int REPEAT_DELAY = 4,
   parameter int REPEAT_RATE  = 1
) (
   input  logic clk,
   input  logic reset,
   input  logic set_mode,
   input  logic btn_inc,
   output logic sec_tick,
   output logic inc_pulse,
   output logic blink,
   output logic running
);

   localparam int PW = (QTR_DIV > 1) ? $clog2(QTR_DIV) : 1;
   localparam logic [PW-1:0] PRE_MAX = PW'(QTR_DIV - 1);

   // Reject parameter values the cadence arithmetic cannot honour.
   if (QTR_DIV < 2 || REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_param_err
      $error("tick_scheduler: QTR_DIV must be >= 2, REPEAT_DELAY and REPEAT_RATE >= 1");
   end

   typedef enum logic [1:0] {
      RUN        = 2'd0,
      SET_IDLE   = 2'd1
`ifdef TICK_SCHED_AUTO_REPEAT_EN
      ,
      SET_HOLD   = 2'd2,
      SET_REPEAT = 2'd3
`endif
   } state_t;

   state_t        state, state_nx;
   logic [PW-1:0] pre, pre_nx, pre_inc;
   logic [1:0]    q, q_nx, q_inc;
   logic          btn_prev;
   logic          qtr, rise;
   logic          sec_nx, inc_nx, blink_nx, running_nx;

`ifdef TICK_SCHED_AUTO_REPEAT_EN
   localparam logic [8:0] DELAY_CNT = 9'(REPEAT_DELAY);
   localparam logic [8:0] RATE_CNT  = 9'(REPEAT_RATE);
   logic [7:0] hold, hold_nx, hold_sat;
   logic [8:0] hold_plus;
   assign hold_plus = {1'b0, hold} + 9'd1;
   assign hold_sat  = (hold == 8'hFF) ? hold : hold + 8'd1;
`endif

   // Free-running prescaler steps; the wrap of pre is the quarter-second event.
   assign qtr     = (pre == PRE_MAX);
   assign pre_inc = qtr ? '0 : pre + 1'b1;
   assign q_inc   = qtr ? q + 2'd1 : q;
   assign rise    = btn_inc & ~btn_prev;

   // State register plus prescaler, hold counter, button history and registered outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= RUN;
         pre       <= '0;
         q         <= 2'd0;
         btn_prev  <= 1'b0;
         sec_tick  <= 1'b0;
         inc_pulse <= 1'b0;
         blink     <= 1'b1;
         running   <= 1'b1;
`ifdef TICK_SCHED_AUTO_REPEAT_EN
         hold      <= 8'd0;
`endif
      end else begin
         state     <= state_nx;
         pre       <= pre_nx;
         q         <= q_nx;
         btn_prev  <= btn_inc;
         sec_tick  <= sec_nx;
         inc_pulse <= inc_nx;
         blink     <= blink_nx;
         running   <= running_nx;
`ifdef TICK_SCHED_AUTO_REPEAT_EN
         hold      <= hold_nx;
`endif
      end
   end

   // Next state and counter updates; leaving set mode wins over any button activity.
   always_comb begin
      state_nx = state;
      pre_nx   = pre_inc;
      q_nx     = q_inc;
`ifdef TICK_SCHED_AUTO_REPEAT_EN
      hold_nx  = hold;
`endif
      if (state != RUN && !set_mode) begin
         // Restart the prescaler so the first second after setting is full length.
         state_nx = RUN;
         pre_nx   = '0;
         q_nx     = 2'd0;
`ifdef TICK_SCHED_AUTO_REPEAT_EN
         hold_nx  = 8'd0;
`endif
      end else begin
         case (state)
            RUN: begin
               if (set_mode) state_nx = SET_IDLE;
            end
            SET_IDLE: begin
               if (rise) begin
                  // A press restarts the blink phase with digits visible.
                  pre_nx   = '0;
                  q_nx     = 2'd0;
`ifdef TICK_SCHED_AUTO_REPEAT_EN
                  hold_nx  = 8'd0;
                  state_nx = SET_HOLD;
`endif
               end
            end
`ifdef TICK_SCHED_AUTO_REPEAT_EN
            SET_HOLD: begin
               if (!btn_inc) begin
                  state_nx = SET_IDLE;
               end else if (qtr) begin
                  if (hold_plus == DELAY_CNT) begin
                     hold_nx  = 8'd0;
                     state_nx = SET_REPEAT;
                  end else begin
                     hold_nx  = hold_sat;
                  end
               end
            end
            SET_REPEAT: begin
               if (!btn_inc) begin
                  state_nx = SET_IDLE;
               end else if (qtr) begin
                  hold_nx = (hold_plus == RATE_CNT) ? 8'd0 : hold_sat;
               end
            end
`endif
            default: state_nx = RUN;
         endcase
      end
   end

   // Strobe and display decisions, registered by the state process.
   always_comb begin
      sec_nx = (state == RUN) && qtr && (q == 2'd3);
      inc_nx = 1'b0;
      if (set_mode) begin
         case (state)
            SET_IDLE:   inc_nx = rise;
`ifdef TICK_SCHED_AUTO_REPEAT_EN
            SET_HOLD:   inc_nx = btn_inc && qtr && (hold_plus == DELAY_CNT);
            SET_REPEAT: inc_nx = btn_inc && qtr && (hold_plus == RATE_CNT);
`endif
            default:    inc_nx = 1'b0;
         endcase
      end
      running_nx = (state_nx == RUN);
      blink_nx   = (state_nx == RUN) ? 1'b1 : ~q_nx[1];
   end

endmodule

// File: tb/tb_tick_scheduler.sv
// Bench for tick_scheduler: directed scenarios then random set_mode / btn_inc / reset traffic.
// Every cycle compares all outputs with a reference model built on elapsed-edge arithmetic.
// Honours TICK_SCHED_AUTO_REPEAT_EN the same way the design does.
module tb_tick_scheduler;

   localparam int QTR_DIV      = 4;
   localparam int REPEAT_DELAY = 4;
   localparam int REPEAT_RATE  = 1;
`ifdef TICK_SCHED_AUTO_REPEAT_EN
   localparam bit AUTO = 1'b1;
`else
   localparam bit AUTO = 1'b0;
`endif

   logic clk = 1'b0;
   logic reset, set_mode, btn_inc;
   logic sec_tick, inc_pulse, blink, running;

   tick_scheduler #(
      .QTR_DIV(QTR_DIV), .REPEAT_DELAY(REPEAT_DELAY), .REPEAT_RATE(REPEAT_RATE)
   ) dut (
      .clk(clk), .reset(reset), .set_mode(set_mode), .btn_inc(btn_inc),
      .sec_tick(sec_tick), .inc_pulse(inc_pulse), .blink(blink), .running(running)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model: m_ph is edges elapsed since the last phase restart
   // (reset, return to run, or a press); everything else follows from it.
   bit m_run = 1'b1, m_held = 1'b0, m_prev = 1'b0;
   int m_ph = 0;
   bit e_sec = 1'b0, e_inc = 1'b0, e_blink = 1'b1, e_running = 1'b1;

   int sec_cnt = 0, inc_cnt = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic bit repeat_due(input int n);
      int first = REPEAT_DELAY * QTR_DIV;
      return (n == first) || (n > first && ((n - first) % (REPEAT_RATE * QTR_DIV)) == 0);
   endfunction

   task automatic model_edge(input bit rst, input bit sm, input bit btn);
      bit qtr_now;
      e_sec = 1'b0;
      e_inc = 1'b0;
      if (rst) begin
         m_run = 1'b1; m_held = 1'b0; m_prev = 1'b0; m_ph = 0;
      end else begin
         qtr_now = (m_ph % QTR_DIV) == QTR_DIV - 1;
         if (m_run) begin
            e_sec = qtr_now && (m_ph % (4 * QTR_DIV)) == 4 * QTR_DIV - 1;
            m_ph++;
            if (sm) m_run = 1'b0;
         end else if (!sm) begin
            m_run = 1'b1; m_held = 1'b0; m_ph = 0;
         end else if (!m_held) begin
            if (btn && !m_prev) begin
               e_inc = 1'b1; m_ph = 0; m_held = AUTO;
            end else begin
               m_ph++;
            end
         end else if (!btn) begin
            m_held = 1'b0; m_ph++;
         end else begin
            m_ph++;
            e_inc = repeat_due(m_ph);
         end
         m_prev = btn;
      end
      e_running = m_run;
      e_blink   = m_run ? 1'b1 : (((m_ph / QTR_DIV) % 4) < 2);
   endtask

   // One clock: model the edge, then compare away from it.
   task automatic cycle();
      @(posedge clk);
      model_edge(reset, set_mode, btn_inc);
      #1;
      check("sec_tick", sec_tick, e_sec);
      check("inc_pulse", inc_pulse, e_inc);
      check("blink", blink, e_blink);
      check("running", running, e_running);
      if (sec_tick === 1'b1) sec_cnt++;
      if (inc_pulse === 1'b1) inc_cnt++;
   endtask

   initial begin
      int first_sec, gap, last_inc;
      reset = 1'b1; set_mode = 1'b0; btn_inc = 1'b0;
      repeat (2) cycle();
      check("reset_blink", blink, 1);
      check("reset_running", running, 1);
      reset = 1'b0;

      // Free run: first tick after edge 16, then every 16.
      sec_cnt = 0; first_sec = -1;
      for (int k = 1; k <= 100; k++) begin
         cycle();
         if (sec_tick === 1'b1 && first_sec < 0) first_sec = k;
      end
      check("free_first_sec", first_sec, 16);
      check("free_sec_count", sec_cnt, 6);

      // Freeze in set mode, then a full-length second after release.
      repeat (10) cycle();
      set_mode = 1'b1;
      sec_cnt = 0;
      repeat (50) cycle();
      check("freeze_sec_count", sec_cnt, 0);
      check("freeze_running", running, 0);
      set_mode = 1'b0;
      cycle();
      gap = 0;
      for (int k = 1; k <= 40; k++) begin
         cycle();
         if (sec_tick === 1'b1) begin gap = k; break; end
      end
      check("resume_sec_gap", gap, 16);

      // Short press.
      set_mode = 1'b1;
      repeat (5) cycle();
      btn_inc = 1'b1;
      inc_cnt = 0;
      cycle();
      check("press_latency", inc_pulse, 1);
      check("press_blink", blink, 1);
      repeat (2) cycle();
      btn_inc = 1'b0;
      repeat (20) cycle();
      check("short_press_count", inc_cnt, 1);

      // Long hold: auto-repeat timing relative to the press edge.
      repeat (3) cycle();
      btn_inc = 1'b1;
      inc_cnt = 0; last_inc = -1;
      for (int k = 0; k < 40; k++) begin
         cycle();
         if (inc_pulse === 1'b1) last_inc = k;
      end
      check("hold_count", inc_cnt, AUTO ? 7 : 1);
      check("hold_last_offset", last_inc, AUTO ? 36 : 0);
      btn_inc = 1'b0;
      inc_cnt = 0;
      repeat (20) cycle();
      check("after_release_count", inc_cnt, 0);

      // set_mode falling together with a button rise.
      cycle();
      set_mode = 1'b0; btn_inc = 1'b1;
      cycle();
      check("collide_inc", inc_pulse, 0);
      check("collide_running", running, 1);
      btn_inc = 1'b0;
      repeat (3) cycle();

      // Reset while auto-repeating.
      set_mode = 1'b1;
      repeat (3) cycle();
      btn_inc = 1'b1;
      repeat (20) cycle();
      reset = 1'b1;
      cycle();
      check("rst_sec", sec_tick, 0);
      check("rst_inc", inc_pulse, 0);
      check("rst_blink", blink, 1);
      check("rst_running", running, 1);
      reset = 1'b0; btn_inc = 1'b0; set_mode = 1'b0;
      repeat (4) cycle();

      // Random traffic.
      for (int k = 0; k < 3000; k++) begin
         reset = ($urandom_range(0, 299) == 0);
         if ($urandom_range(0, 39) == 0) set_mode = ~set_mode;
         if ($urandom_range(0, 11) == 0) btn_inc = ~btn_inc;
         cycle();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
